// File: rtl/rv32i_types.sv
// Shared fetch-stage types: FSM encoding, reset PC, epoch tag and hold-buffer payload.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rv32i_types;

    localparam logic [31:0] FETCH_RESET_PC = 32'h6000_0000;

    typedef logic [2:0] branch_id_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dat;
    } fetch_hold_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry parking register for an instruction that arrived while decode was stalled.
// Latency: capture visible on the next cycle; clear has priority over capture.
// Backpressure: none; the owner decides when to capture and when to release.
module fetch_hold_buf
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        capture,
    input  logic        clear,
    input  logic [31:0] cap_pc,
    input  logic [31:0] cap_dat,
    output logic        hold_vld,
    output logic [31:0] hold_pc,
    output logic [31:0] hold_dat
);

    fetch_hold_t entry;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld <= 1'b0;
            entry    <= '0;
        end else if (clear) begin
            hold_vld <= 1'b0;
        end else if (capture) begin
            hold_vld <= 1'b1;
            entry    <= '{pc: cap_pc, dat: cap_dat};
        end
    end

    assign hold_pc  = entry.pc;
    assign hold_dat = entry.dat;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the imem read handshake, loads the IR with an epoch tag (perf counters under FETCH_PERF_CTR_EN).
// Latency: ir_load is combinational with imem_resp; one instruction per two cycles with single-cycle memory.
// Backpressure: stall parks a response in the hold buffer and suspends reads until decode accepts it.
module fetch_ctrl
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
    parameter int          BID_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_read,
    output logic [31:0]      imem_address,
    input  logic             imem_resp,
    input  logic [31:0]      imem_rdata,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             ir_load,
    output logic [31:0]      ir_in,
    output logic [31:0]      ir_pc,
    output logic [BID_W-1:0] branch_id_out
`ifdef FETCH_PERF_CTR_EN
    ,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_dropped
`endif
);

    fetch_state_t     state, state_nxt;
    logic [31:0]      pc, pc_nxt;
    logic [31:0]      drain_addr, drain_nxt;
    logic [BID_W-1:0] epoch, epoch_nxt;

    logic        hb_capture, hb_clear, hb_vld;
    logic [31:0] hb_pc, hb_dat;

    fetch_hold_buf u_hold (
        .clk      (clk),
        .rst      (rst),
        .capture  (hb_capture),
        .clear    (hb_clear),
        .cap_pc   (pc),
        .cap_dat  (imem_rdata),
        .hold_vld (hb_vld),
        .hold_pc  (hb_pc),
        .hold_dat (hb_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            epoch      <= '0;
            drain_addr <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            epoch      <= epoch_nxt;
            drain_addr <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        epoch_nxt     = epoch;
        drain_nxt     = drain_addr;
        imem_read     = 1'b0;
        imem_address  = pc;
        ir_load       = 1'b0;
        ir_in         = '0;
        ir_pc         = '0;
        branch_id_out = '0;
        hb_capture    = 1'b0;
        hb_clear      = 1'b0;

        case (state)
            IDLE: state_nxt = REQ;

            REQ: begin
                imem_read = 1'b1;
                if (redirect_valid) begin
                    // A response landing with the redirect is simply dropped; otherwise wait it out.
                    if (!imem_resp) begin
                        drain_nxt = pc;
                        state_nxt = DRAIN;
                    end
                end else if (imem_resp) begin
                    if (stall) begin
                        hb_capture = 1'b1;
                        state_nxt  = HOLD;
                    end else begin
                        ir_load       = 1'b1;
                        ir_in         = imem_rdata;
                        ir_pc         = pc;
                        branch_id_out = epoch;
                        pc_nxt        = pc + 32'd4;
                    end
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    hb_clear  = 1'b1;
                    state_nxt = REQ;
                end else if (!stall) begin
                    ir_load       = hb_vld;
                    ir_in         = hb_dat;
                    ir_pc         = hb_pc;
                    branch_id_out = epoch;
                    hb_clear      = 1'b1;
                    pc_nxt        = hb_vld ? pc + 32'd4 : pc;
                    state_nxt     = REQ;
                end
            end

            DRAIN: begin
                imem_read    = 1'b1;
                imem_address = drain_addr;
                // The stale read completing ends the drain even if another redirect arrives with it.
                if (imem_resp) state_nxt = REQ;
            end

            default: state_nxt = IDLE;
        endcase

        if (redirect_valid) begin
            pc_nxt    = align_pc(redirect_pc);
            epoch_nxt = epoch + BID_W'(1);
            if (state == IDLE) state_nxt = REQ;
        end
    end

`ifdef FETCH_PERF_CTR_EN
    logic resp_drop;
    assign resp_drop = imem_resp && ((state == REQ && redirect_valid) || state == DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (ir_load && perf_fetched != 32'hFFFF_FFFF) perf_fetched <= perf_fetched + 32'd1;
            if (resp_drop && perf_dropped != 32'hFFFF_FFFF) perf_dropped <= perf_dropped + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: transaction-level reference model, variable-latency memory, directed scenarios then random traffic.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ir_load;
    logic [31:0] ir_in;
    logic [31:0] ir_pc;
    logic [2:0]  branch_id_out;
`ifdef FETCH_PERF_CTR_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .imem_read      (imem_read),
        .imem_address   (imem_address),
        .imem_resp      (imem_resp),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ir_load        (ir_load),
        .ir_in          (ir_in),
        .ir_pc          (ir_pc),
        .branch_id_out  (branch_id_out)
`ifdef FETCH_PERF_CTR_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory: one read at a time, answers mem_lat cycles after it accepts a request.
    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_wait;
    int          mem_lat = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Reference model: where fetch is, what epoch it is in, any parked word, any abandoned read.
    bit          m_started, m_held_v, m_stale, chk_zero;
    logic [31:0] m_pc, m_stale_addr, m_hdat, m_hpc;
    int unsigned m_epoch;

    logic        o_read, o_load;
    logic [31:0] o_addr, o_pc, o_ins;
    logic [2:0]  o_bid;

    task automatic do_reset(input int n);
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_resp = 1'b0; imem_rdata = '0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        mem_busy = 0; mem_wait = 0; mem_addr = '0;
        m_started = 0; m_held_v = 0; m_stale = 0; m_pc = 32'h6000_0000; m_epoch = 0;
        chk_zero = 1;
    endtask

    task automatic step(input logic st, input logic rv, input logic [31:0] rp);
        logic        e_read, e_load;
        logic [31:0] e_addr, e_ins, e_pc, old_pc;
        logic [2:0]  e_bid;
        imem_resp      = mem_busy && (mem_wait == 0);
        imem_rdata     = imem_resp ? mem_word(mem_addr) : $urandom;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rp;
        #2;
        e_read = m_started && !m_held_v;
        e_addr = m_stale ? m_stale_addr : m_pc;
        e_load = 0; e_ins = 0; e_pc = 0;
        e_bid  = 3'(m_epoch % 8);
        if (m_started && !rv && !st) begin
            if (m_held_v) begin
                e_load = 1; e_ins = m_hdat; e_pc = m_hpc;
            end else if (imem_resp && !m_stale) begin
                e_load = 1; e_ins = imem_rdata; e_pc = m_pc;
            end
        end
        o_read = imem_read; o_addr = imem_address; o_load = ir_load;
        o_ins = ir_in; o_pc = ir_pc; o_bid = branch_id_out;
        chk("imem_read", 32'(o_read), 32'(e_read));
        if (e_read) chk("imem_address", o_addr, e_addr);
        chk("ir_load", 32'(o_load), 32'(e_load));
        if (e_load) begin
            chk("ir_in", o_ins, e_ins);
            chk("ir_pc", o_pc, e_pc);
            chk("branch_id_out", 32'(o_bid), 32'(e_bid));
        end
        if (chk_zero) begin
            chk("reset_ir_in", o_ins, 32'h0);
            chk("reset_ir_pc", o_pc, 32'h0);
            chk("reset_branch_id", 32'(o_bid), 32'h0);
            chk_zero = 0;
        end
        old_pc = m_pc;
        if (rv) begin
            m_pc = rp & 32'hFFFF_FFFC;
            m_epoch++;
            if (!m_started) m_started = 1;
            else if (m_held_v) m_held_v = 0;
            else if (imem_resp) m_stale = 0;
            else if (!m_stale) begin m_stale = 1; m_stale_addr = old_pc; end
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_held_v) begin
            if (!st) begin m_held_v = 0; m_pc += 4; end
        end else if (imem_resp) begin
            if (m_stale) m_stale = 0;
            else if (st) begin m_held_v = 1; m_hdat = imem_rdata; m_hpc = m_pc; end
            else m_pc += 4;
        end
        if (mem_busy) begin
            if (imem_resp) mem_busy = 0;
            else mem_wait--;
        end else if (imem_read) begin
            mem_busy = 1; mem_addr = imem_address; mem_wait = mem_lat - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_load(input string name);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (o_load) return;
        end
        chk({name, "_timeout"}, 32'(o_load), 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Straight-line fetch, single-cycle memory.
        do_reset(2);
        mem_lat = 1;
        for (int c = 0; c < 7; c++) begin
            step(1'b0, 1'b0, 32'h0);
            case (c)
                0: chk("t1_idle_read", 32'(o_read), 32'h0);
                1: chk("t1_addr0", o_addr, 32'h6000_0000);
                2: chk("t1_load_pc0", o_pc, 32'h6000_0000);
                4: chk("t1_load_pc1", o_pc, 32'h6000_0004);
                5: chk("t1_addr2", o_addr, 32'h6000_0008);
                6: begin
                    chk("t1_load_pc2", o_pc, 32'h6000_0008);
                    chk("t1_bid", 32'(o_bid), 32'h0);
                end
                default: ;
            endcase
        end

        // Stall while the response for 0x6000_0004 returns.
        do_reset(2);
        for (int c = 0; c < 9; c++) begin
            step(c >= 4 && c <= 6, 1'b0, 32'h0);
            case (c)
                4: chk("t2_no_load_stalled", 32'(o_load), 32'h0);
                5: chk("t2_hold_read", 32'(o_read), 32'h0);
                6: chk("t2_hold_load", 32'(o_load), 32'h0);
                7: begin
                    chk("t2_release_load", 32'(o_load), 32'h1);
                    chk("t2_release_pc", o_pc, 32'h6000_0004);
                    chk("t2_release_ins", o_ins, mem_word(32'h6000_0004));
                end
                8: chk("t2_next_addr", o_addr, 32'h6000_0008);
                default: ;
            endcase
        end

        // Redirect while the read at 0x6000_0008 is outstanding.
        do_reset(2);
        for (int c = 0; c < 11; c++) begin
            mem_lat = (c == 5) ? 3 : 1;
            step(1'b0, c == 6, 32'h6000_0100);
            case (c)
                7: chk("t3_drain_addr", o_addr, 32'h6000_0008);
                8: begin
                    chk("t3_drop_load", 32'(o_load), 32'h0);
                    chk("t3_drop_addr", o_addr, 32'h6000_0008);
                end
                9: chk("t3_new_addr", o_addr, 32'h6000_0100);
                10: begin
                    chk("t3_load_pc", o_pc, 32'h6000_0100);
                    chk("t3_bid", 32'(o_bid), 32'h1);
                end
                default: ;
            endcase
        end

        // Redirect coinciding with a response; target low bits must be ignored.
        do_reset(2);
        mem_lat = 1;
        for (int c = 0; c < 5; c++) begin
            step(1'b0, c == 2, 32'h6000_0203);
            case (c)
                2: chk("t4_no_load", 32'(o_load), 32'h0);
                3: chk("t4_addr", o_addr, 32'h6000_0200);
                4: chk("t4_bid", 32'(o_bid), 32'h1);
                default: ;
            endcase
        end

        // Eight redirects wrap the epoch; then a PC that wraps past the top of memory.
        do_reset(2);
        for (int c = 0; c < 7; c++) step(1'b0, 1'b1, 32'h6000_1000 + 32'(c * 16));
        wait_load("t5a");
        chk("t5_bid7", 32'(o_bid), 32'h7);
        chk("t5_pc7", o_pc, 32'h6000_1060);
        step(1'b0, 1'b1, 32'hFFFF_FFFD);
        wait_load("t5b");
        chk("t5_bid_wrap", 32'(o_bid), 32'h0);
        chk("t5_pc_top", o_pc, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        chk("t5_pc_wrap", o_addr, 32'h0000_0000);

        // Reset while draining.
        do_reset(2);
        mem_lat = 3;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h6000_0400);
        step(1'b0, 1'b0, 32'h0);
        chk("t6_in_drain", o_addr, 32'h6000_0000);
        do_reset(1);
        step(1'b0, 1'b0, 32'h0);
        chk("t6_reset_read", 32'(o_read), 32'h0);
        chk("t6_reset_load", 32'(o_load), 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("t6_restart_addr", o_addr, 32'h6000_0000);

        // Random traffic against the model.
        do_reset(2);
        for (int c = 0; c < 4000; c++) begin
            logic [31:0] rp;
            mem_lat = $urandom_range(1, 3);
            rp = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            if ($urandom % 1000 == 0) do_reset(1);
            step(($urandom % 100) < 30, ($urandom % 100) < 8, rp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Front-end sequencer for the fetch stage.
- Owns the fetch PC and drives the instruction-memory read handshake.
- Generates the load strobe, instruction word, PC and 3-bit branch_id (epoch) tag for the instruction register feeding decode.
- Handles decode back-pressure and control-flow redirects: responses belonging to a stale epoch are discarded, never loaded.

Parameters:
- RESET_PC, 32'h6000_0000, fetch address after reset.
- BID_W, 3, width of branch_id epoch tag; wraps modulo 2^BID_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- imem_read  out  1  instruction read request; held until imem_resp.
- imem_address  out  32  read address; stable while imem_read=1.
- imem_resp  in  1  one-cycle read completion.
- imem_rdata  in  32  instruction word; valid with imem_resp.
- stall  in  1  decode cannot accept; IR must not load.
- redirect_valid  in  1  one-cycle control-flow redirect.
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
- ir_load  out  1  IR load strobe.
- ir_in  out  32  instruction to IR.
- ir_pc  out  32  PC of ir_in.
- branch_id_out  out  BID_W  epoch tag accompanying ir_in.

Behaviour:
- Reset values:
  - pc=RESET_PC, epoch=0, state=IDLE.
  - imem_read=0, ir_load=0, ir_in=0, ir_pc=0, branch_id_out=0.
  - Hold buffer cleared.
- States:
  - IDLE: one cycle after reset. Next state REQ. No request issued.
  - REQ:
    - imem_read=1, imem_address=pc.
    - On imem_resp & !redirect_valid & !stall: ir_load=1 (combinational, same cycle), ir_in=imem_rdata, ir_pc=pc, branch_id_out=epoch; pc<=pc+4; stay in REQ. The next request issues the following cycle at the new pc.
    - On imem_resp & !redirect_valid & stall: capture rdata/pc into the hold buffer; go to HOLD.
  - HOLD:
    - imem_read=0.
    - When !stall: ir_load=1 from the buffer with the current epoch; pc<=pc+4; go to REQ.
  - DRAIN:
    - Entered when a redirect arrives while a request is outstanding and imem_resp is not in that cycle.
    - imem_read=1, imem_address=drain_addr, the address latched at the redirect.
    - On imem_resp: discard the data; go to REQ. ir_load stays 0 throughout.
- Redirect: highest priority in every state.
  - pc<=redirect_pc, epoch<=epoch+1 (wraps 7->0), ir_load=0 that cycle.
  - REQ with imem_resp in the same cycle: discard the response, stay in REQ.
  - REQ without imem_resp: latch drain_addr=pc, go to DRAIN.
  - HOLD: drop the buffer, go to REQ.
  - DRAIN: update pc and epoch again, stay in DRAIN; drain_addr is unchanged.
  - IDLE: update pc and epoch, go to REQ.
- imem_address never changes while imem_read=1 and imem_resp has not been seen.
- stall without a response present in REQ has no effect.
- ir_load is never 1 while stall=1 or redirect_valid=1.
- pc arithmetic is 32-bit and wraps 0xFFFF_FFFC->0.
- Reset mid-operation: an outstanding read is abandoned and the FSM returns to IDLE. The memory is also reset by rst, so no response can arrive after reset.
- Latency: redirect to first ir_load is at least 2 cycles (request cycle + response). Back-to-back throughput is one instruction per 2 cycles with single-cycle memory.

Optional Feature:
- FETCH_PERF_CTR_EN defined:
  - Adds outputs perf_fetched (32-bit): +1 per ir_load.
  - Adds outputs perf_dropped (32-bit): +1 per imem_resp discarded due to redirect or DRAIN.
  - Both counters reset to 0 and saturate at 0xFFFF_FFFF.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package rv32i_types:
  - fetch_state_t enum {IDLE, REQ, HOLD, DRAIN}.
  - Constant FETCH_RESET_PC.
  - Typedef branch_id_t = logic [2:0].
- One natural sub-module: fetch_hold_buf.
  - Single-entry data/pc register with capture/clear/valid.
  - Used by HOLD.

Test Plan:
- Reset, memory responds every cycle after read, stall=0 -> reads at 0x6000_0000, 0x6000_0004, 0x6000_0008; ir_load pulses carry those pcs, branch_id_out=0.
- stall=1 for 3 cycles when resp for 0x6000_0004 returns -> imem_read=0 during HOLD, ir_load=0; ir_load fires with the held word the cycle after stall drops; next read at 0x6000_0008.
- redirect_valid with redirect_pc=0x6000_0100 while read outstanding at 0x6000_0008, resp 2 cycles later -> imem_address stays 0x6000_0008 until resp, data dropped; next read at 0x6000_0100; ir_load shows branch_id_out=1.
- Redirect in the same cycle as imem_resp -> no ir_load; next read at redirect_pc; epoch increments.
- 8 consecutive redirects -> branch_id_out wraps 7->0.
- rst asserted in DRAIN -> next cycle all outputs at reset values; read restarts at 0x6000_0000 after IDLE.
